decode_stage: RTL and testbench
===============================

# decode_stage

Second stage of the RV32I five-stage pipeline. Consumes the IF/ID outputs (`instruction`, `pc`, `pc4`) from the fetch stage. Decodes control, reads the 32×32 register file and generates the sign-extended immediate, then registers everything into the ID/EX pipeline register. Also owns the register-file write port driven from writeback.

## Interface
- Parameters: none; widths fixed at RV32 (XLEN=32, 32 architectural registers).
- Reset: one clock `clk`; reset `rst` is asynchronous and active-low.
- `clk` in 1: pipeline clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `instruction` in 32: instruction from IF/ID.
- `pc` in 32: PC of that instruction.
- `pc4` in 32: PC+4 of that instruction.
- `regwrite_w` in 1: writeback register-file write enable.
- `rd_w` in 5: writeback destination register.
- `result_w` in 32: writeback data.
- `flush` in 1: turns the next ID/EX contents into a bubble (taken branch/jump).
- `regwrite_e`, `memwrite_e`, `alusrc_e`, `branch_e`, `jump_e` out 1 each: registered control bits.
- `resultsrc_e` out 2: result select; 00 ALU, 01 memory, 10 pc4.
- `alucontrol_e` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `rd1_e`, `rd2_e` out 32: register operands for rs1 and rs2.
- `imm_e` out 32: sign-extended immediate.
- `rs1_e`, `rs2_e`, `rd_e` out 5: register indices, for the hazard unit.
- `pc_e`, `pc4_e` out 32: forwarded PC values.

## Operation
- **Main decode**, by opcode:
  - lw 0000011: regwrite, alusrc, resultsrc=01, immsrc I, aluop 00.
  - sw 0100011: memwrite, alusrc, immsrc S, aluop 00.
  - R-type 0110011: regwrite, aluop 10.
  - I-ALU 0010011: regwrite, alusrc, immsrc I, aluop 10.
  - beq 1100011: branch, immsrc B, aluop 01.
  - jal 1101111: regwrite, jump, resultsrc=10, immsrc J.
  - Any other opcode: all control bits 0 (bubble).
- **ALU decode**:
  - aluop 00 gives add; aluop 01 gives sub.
  - aluop 10 selects by funct3: 000 gives sub only when R-type with funct7[5]=1, else add; 010 slt; 110 or; 111 and; any other funct3 gives add.
- **Immediate**, always sign-extended from instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- **Register file**:
  - Reads are combinational on rs1 = instr[19:15] and rs2 = instr[24:20].
  - A write occurs on posedge when `regwrite_w` is high and `rd_w` ≠ 0.
  - x0 always reads 0.
  - Internal bypass: if `regwrite_w` is high, `rd_w` ≠ 0 and `rd_w` equals rs1 or rs2 in the same cycle, the read returns `result_w`.
- **ID/EX register**: on each posedge, captures all decoded values; rd = instr[11:7].
- **Flush**: if `flush` is high at a posedge, every `_e` output is loaded with 0 instead of the decoded values. `flush` wins over any instruction being decoded. A register-file write in that same cycle still happens.

## Timing
- Latency: an instruction present on the inputs before posedge N appears on the `_e` outputs after posedge N. Exactly one cycle.
- A writeback at posedge N is visible to a read in the same cycle N (bypass) and in every later cycle.
- `rst` low, asynchronous at any time, including mid-stream:
  - every `_e` output goes to 0 immediately;
  - all 32 registers clear to 0.
- First capture happens on the first posedge after `rst` rises.
- There is no stall input. The stage advances every cycle.
- Boundaries:
  - `rd_w` = 0 with `regwrite_w` high: no write, no bypass.
  - rs1 = rs2 = `rd_w`: both operands are bypassed.
  - Sign extension of negative immediates yields a full 32-bit two's-complement value.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - the `alucontrol` encodings;
  - `immsrc` (IMM_I/S/B/J) and `resultsrc` encodings.
- One sub-module, `reg_file`: 32×32 storage, two read ports, one write port, async active-low clear, internal write-to-read bypass.
- Control decode, immediate generation and the ID/EX register stay in `decode_stage`.

## Test plan
- **Reset:** assert `rst`=0 mid-stream.
  - All `_e` outputs read 0 without waiting for a clock edge.
  - After release, reading x5 returns 0.
- **addi:** `instruction`=0x00500093 (addi x1,x0,5).
  - Next cycle: `regwrite_e`=1, `alusrc_e`=1, `alucontrol_e`=000, `imm_e`=5, `rd_e`=1, `rd1_e`=0.
- **Bypass:** `regwrite_w`=1, `rd_w`=2, `result_w`=0xDEADBEEF, in the same cycle as 0x002101B3 (add x3,x2,x2).
  - `rd1_e` = `rd2_e` = 0xDEADBEEF.
  - Repeat with `rd_w`=0: x0 still reads 0.
- **Store and branch:**
  - 0x00512423 (sw x5,8(x2)) gives `memwrite_e`=1, `regwrite_e`=0, `imm_e`=8.
  - 0xFE000EE3 (beq x0,x0,-4) gives `branch_e`=1, `alucontrol_e`=001, `imm_e`=0xFFFFFFFC.
- **Jump:** 0x010000EF (jal x1,16) with `pc`=0x100.
  - `jump_e`=1, `resultsrc_e`=10, `imm_e`=16, `pc_e`=0x100, `pc4_e`=0x104.
- **Flush:** `flush`=1 with 0x00500093 on the inputs.
  - Next cycle: all `_e` outputs are 0.
  - A simultaneous writeback to x7 is still committed: a later read of x7 returns the written value.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU/result/immediate encodings,
// and the immediate sign-extension helper used by the decode stage.
package riscv_pkg;

  // Major opcodes handled by the main decoder
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation encodings seen by the execute stage
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Main-decoder to ALU-decoder hint
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Immediate format select
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  // Reassemble and sign-extend (from instr[31]) the immediate of a given format
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input immsrc_t src);
    logic [31:0] imm;
    unique case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: two combinational read ports, one
// write port, asynchronous active-low clear, and write-to-read bypass so a
// value being written back this cycle is seen by the instruction in decode.
module reg_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic        wr_en;

  // x0 is hardwired, so a write aimed at it is simply dropped
  assign wr_en = we && (wa != 5'd0);

  // Register storage; cleared asynchronously so reset needs no clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write is bypassed ahead of storage
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (wr_en && (wa == ra1)) rd1 = wd;
    if (wr_en && (wa == ra2)) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: main/ALU control decode, register read, immediate
// generation and the ID/EX pipeline register. Also owns the register-file
// write port driven by writeback.
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic        regwrite_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  input  logic        flush,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic        alusrc_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [1:0]  resultsrc_e,
  output logic [2:0]  alucontrol_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc4_e
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1, rs2, rd;

  logic        regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d;
  logic [1:0]  resultsrc_d;
  logic [1:0]  aluop;
  immsrc_t     immsrc;
  logic [2:0]  alucontrol_d;
  logic [31:0] imm_d;
  logic [31:0] rd1_d, rd2_d;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign rd       = instruction[11:7];

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .we  (regwrite_w),
    .wa  (rd_w),
    .wd  (result_w),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  // Main decoder: opcode to control bits; unknown opcodes become a bubble
  always_comb begin
    regwrite_d  = 1'b0;
    memwrite_d  = 1'b0;
    alusrc_d    = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    resultsrc_d = RES_ALU;
    aluop       = ALUOP_ADD;
    immsrc      = IMM_I;
    unique case (opcode)
      OP_LW: begin
        regwrite_d  = 1'b1;
        alusrc_d    = 1'b1;
        resultsrc_d = RES_MEM;
        immsrc      = IMM_I;
      end
      OP_SW: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        immsrc     = IMM_S;
      end
      OP_R: begin
        regwrite_d = 1'b1;
        aluop      = ALUOP_FUNCT;
      end
      OP_I: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        aluop      = ALUOP_FUNCT;
        immsrc     = IMM_I;
      end
      OP_BEQ: begin
        branch_d = 1'b1;
        aluop    = ALUOP_SUB;
        immsrc   = IMM_B;
      end
      OP_JAL: begin
        regwrite_d  = 1'b1;
        jump_d      = 1'b1;
        resultsrc_d = RES_PC4;
        immsrc      = IMM_J;
      end
      default: ;
    endcase
  end

  // ALU decoder: funct7[5] means sub only for register-register ops,
  // since on I-type that bit belongs to the immediate
  always_comb begin
    alucontrol_d = ALU_ADD;
    unique case (aluop)
      ALUOP_SUB: alucontrol_d = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alucontrol_d = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_d = ALU_SLT;
          3'b110:  alucontrol_d = ALU_OR;
          3'b111:  alucontrol_d = ALU_AND;
          default: alucontrol_d = ALU_ADD;
        endcase
      end
      default: alucontrol_d = ALU_ADD;
    endcase
  end

  assign imm_d = imm_gen(instruction, immsrc);

  // ID/EX register: cleared by reset, loaded with a bubble on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || 1'b0) begin
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      resultsrc_e  <= '0;
      alucontrol_e <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      pc_e         <= '0;
      pc4_e        <= '0;
    end else if (flush) begin
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
      resultsrc_e  <= '0;
      alucontrol_e <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      pc_e         <= '0;
      pc4_e        <= '0;
    end else begin
      regwrite_e   <= regwrite_d;
      memwrite_e   <= memwrite_d;
      alusrc_e     <= alusrc_d;
      branch_e     <= branch_d;
      jump_e       <= jump_d;
      resultsrc_e  <= resultsrc_d;
      alucontrol_e <= alucontrol_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      imm_e        <= imm_d;
      rs1_e        <= rs1;
      rs2_e        <= rs2;
      rd_e         <= rd;
      pc_e         <= pc;
      pc4_e        <= pc4;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each step drives one instruction (plus an
// optional writeback), queues the expected ID/EX contents, and checks them
// one cycle later.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc, pc4;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        flush;
  logic        regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e;
  logic [1:0]  resultsrc_e;
  logic [2:0]  alucontrol_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [4:0]  ctl;      // {regwrite, memwrite, alusrc, branch, jump}
    logic [1:0]  resultsrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1, rd2, imm;
    logic        chk_imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } exp_t;

  exp_t sb_q[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .pc4(pc4),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w), .flush(flush),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .alusrc_e(alusrc_e),
    .branch_e(branch_e), .jump_e(jump_e), .resultsrc_e(resultsrc_e),
    .alucontrol_e(alucontrol_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .pc4_e(pc4_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {27'd0, regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e}, 32'd0);
    chk({tag, ".resultsrc"}, {30'd0, resultsrc_e}, 32'd0);
    chk({tag, ".alucontrol"}, {29'd0, alucontrol_e}, 32'd0);
    chk({tag, ".rd1"}, rd1_e, 32'd0);
    chk({tag, ".rd2"}, rd2_e, 32'd0);
    chk({tag, ".imm"}, imm_e, 32'd0);
    chk({tag, ".regs"}, {17'd0, rs1_e, rs2_e, rd_e}, 32'd0);
    chk({tag, ".pc"}, pc_e, 32'd0);
    chk({tag, ".pc4"}, pc4_e, 32'd0);
  endtask

  // Drive one decode cycle, queue its expectation, then check it after the edge
  task automatic step(input logic [31:0] ins, input logic [31:0] p, input logic fl,
                      input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input exp_t e);
    exp_t got_e;
    @(negedge clk);
    instruction = ins; pc = p; pc4 = p + 32'd4; flush = fl;
    regwrite_w = wv; rd_w = wa; result_w = wd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    regwrite_w = 1'b0; flush = 1'b0;
    got_e = sb_q.pop_front();
    chk({got_e.name, ".ctl"}, {27'd0, regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e},
        {27'd0, got_e.ctl});
    chk({got_e.name, ".resultsrc"}, {30'd0, resultsrc_e}, {30'd0, got_e.resultsrc});
    chk({got_e.name, ".alucontrol"}, {29'd0, alucontrol_e}, {29'd0, got_e.alucontrol});
    chk({got_e.name, ".rd1"}, rd1_e, got_e.rd1);
    chk({got_e.name, ".rd2"}, rd2_e, got_e.rd2);
    if (got_e.chk_imm) chk({got_e.name, ".imm"}, imm_e, got_e.imm);
    chk({got_e.name, ".rs1"}, {27'd0, rs1_e}, {27'd0, got_e.rs1});
    chk({got_e.name, ".rs2"}, {27'd0, rs2_e}, {27'd0, got_e.rs2});
    chk({got_e.name, ".rd"}, {27'd0, rd_e}, {27'd0, got_e.rd});
    chk({got_e.name, ".pc"}, pc_e, got_e.pc);
    chk({got_e.name, ".pc4"}, pc4_e, got_e.pc4);
    $display("step %-8s instr=%h pc=%h checks=%0d errors=%0d", got_e.name, ins, p, checks, errors);
  endtask

  initial begin
    rst = 1'b0; instruction = '0; pc = '0; pc4 = '0;
    regwrite_w = 1'b0; rd_w = '0; result_w = '0; flush = 1'b0;
    #3;
    chk_all_zero("por");
    @(negedge clk); rst = 1'b1;

    //      ins           pc      fl wv wa     wd
    // name ctl{rw,mw,as,br,j} rsrc alu rd1 rd2 imm chk rs1 rs2 rd pc pc4
    step(32'h00500093, 32'h000, 0, 0, 5'd0, 32'h0,
         '{"addi",   5'b10100, 2'b00, 3'b000, 32'h0, 32'h0, 32'd5, 1, 5'd0, 5'd5, 5'd1, 32'h000, 32'h004});
    step(32'h002101B3, 32'h004, 0, 1, 5'd2, 32'hDEADBEEF,
         '{"bypass", 5'b10000, 2'b00, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 5'd2, 5'd2, 5'd3, 32'h004, 32'h008});
    step(32'h000001B3, 32'h008, 0, 1, 5'd0, 32'h12345678,
         '{"x0wr",   5'b10000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 5'd3, 32'h008, 32'h00C});
    step(32'h002101B3, 32'h00C, 0, 1, 5'd0, 32'h12345678,
         '{"nobyp",  5'b10000, 2'b00, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 5'd2, 5'd2, 5'd3, 32'h00C, 32'h010});
    step(32'h40110233, 32'h010, 0, 0, 5'd0, 32'h0,
         '{"sub",    5'b10000, 2'b00, 3'b001, 32'hDEADBEEF, 32'h0, 32'h0, 0, 5'd2, 5'd1, 5'd4, 32'h010, 32'h014});
    step(32'h40000293, 32'h014, 0, 0, 5'd0, 32'h0,
         '{"addi400",5'b10100, 2'b00, 3'b000, 32'h0, 32'h0, 32'h400, 1, 5'd0, 5'd0, 5'd5, 32'h014, 32'h018});
    step(32'h00212333, 32'h018, 0, 0, 5'd0, 32'h0,
         '{"slt",    5'b10000, 2'b00, 3'b101, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 5'd2, 5'd2, 5'd6, 32'h018, 32'h01C});
    step(32'h00216333, 32'h01C, 0, 0, 5'd0, 32'h0,
         '{"or",     5'b10000, 2'b00, 3'b011, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 5'd2, 5'd2, 5'd6, 32'h01C, 32'h020});
    step(32'h00217333, 32'h020, 0, 0, 5'd0, 32'h0,
         '{"and",    5'b10000, 2'b00, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 0, 5'd2, 5'd2, 5'd6, 32'h020, 32'h024});
    step(32'h00512423, 32'h024, 0, 1, 5'd5, 32'h00000055,
         '{"sw",     5'b01100, 2'b00, 3'b000, 32'hDEADBEEF, 32'h55, 32'd8, 1, 5'd2, 5'd5, 5'd8, 32'h024, 32'h028});
    step(32'hFE000EE3, 32'h028, 0, 0, 5'd0, 32'h0,
         '{"beq",    5'b00010, 2'b00, 3'b001, 32'h0, 32'h0, 32'hFFFFFFFC, 1, 5'd0, 5'd0, 5'd29, 32'h028, 32'h02C});
    step(32'h010000EF, 32'h100, 0, 0, 5'd0, 32'h0,
         '{"jal",    5'b10001, 2'b10, 3'b000, 32'h0, 32'h0, 32'd16, 1, 5'd0, 5'd16, 5'd1, 32'h100, 32'h104});
    step(32'h00500093, 32'h104, 1, 1, 5'd7, 32'hCAFEF00D,
         '{"flush",  5'b00000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0});
    step(32'h00738433, 32'h108, 0, 0, 5'd0, 32'h0,
         '{"rdx7",   5'b10000, 2'b00, 3'b000, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 0, 5'd7, 5'd7, 5'd8, 32'h108, 32'h10C});
    step(32'h0000007F, 32'h10C, 0, 0, 5'd0, 32'h0,
         '{"badop",  5'b00000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 32'h10C, 32'h110});
    step(32'h00500093, 32'h110, 0, 0, 5'd0, 32'h0,
         '{"preRst", 5'b10100, 2'b00, 3'b000, 32'h0, 32'h55, 32'd5, 1, 5'd0, 5'd5, 5'd1, 32'h110, 32'h114});

    // Mid-stream asynchronous reset, checked before any clock edge
    #2 rst = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk); rst = 1'b1;

    step(32'h00728533, 32'h200, 0, 0, 5'd0, 32'h0,
         '{"postRst",5'b10000, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 5'd5, 5'd7, 5'd10, 32'h200, 32'h204});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
